// File: rtl/riscv_dmem_arbiter.sv
// Data-memory arbiter: CPU load/store traffic shares the single memory port with
// queued UART-programmer writes; the CPU has priority, bounded by a starvation limit.
module riscv_dmem_arbiter #(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              upg_wen,
   input  logic [ADDR_W-1:0] upg_adr,
   input  logic [31:0]       upg_dat,
   output logic              upg_full,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              prog_busy,
   output logic              ovf_err
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

   typedef enum logic {S_IDLE, S_RD_DATA} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fifo_adr_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_adr_d [FIFO_DEPTH];
   logic [31:0]       fifo_dat_q [FIFO_DEPTH];
   logic [31:0]       fifo_dat_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              ovf_q, ovf_d;

   logic empty, full, grant_upg, grant_cpu, push, pop;

   always_comb begin
      state_d     = state_q;
      fifo_adr_d  = fifo_adr_q;
      fifo_dat_d  = fifo_dat_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      starve_d    = starve_q;
      cpu_rdata_d = cpu_rdata_q;
      ovf_d       = ovf_q;
      grant_upg   = 1'b0;
      grant_cpu   = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      cpu_stall   = 1'b0;
      cpu_rdata   = cpu_rdata_q;

      empty     = (count_q == '0);
      full      = (count_q == CNT_W'(FIFO_DEPTH));
      upg_full  = full;
      prog_busy = !empty;

      case (state_q)
         S_IDLE: begin
            grant_upg = !empty && (!cpu_req || (starve_q == ST_W'(STARVE_MAX)));
            grant_cpu = cpu_req && !grant_upg;
            if (grant_upg) begin
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = fifo_adr_q[rd_ptr_q];
               mem_wdata = fifo_dat_q[rd_ptr_q];
               cpu_stall = cpu_req;
            end else if (grant_cpu) begin
               mem_en = 1'b1;
               mem_we = cpu_we;
               if (!cpu_we) begin
                  cpu_stall = 1'b1;
                  state_d   = S_RD_DATA;
               end
            end
         end
         S_RD_DATA: begin
            cpu_rdata   = mem_rdata;
            cpu_rdata_d = mem_rdata;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Starve count only advances while a queued write is passed over by a CPU grant.
      if (grant_upg || empty) begin
         starve_d = '0;
      end else if (grant_cpu && (starve_q != ST_W'(STARVE_MAX))) begin
         starve_d = starve_q + ST_W'(1);
      end

      pop  = grant_upg;
      push = upg_wen && !full;
      if (upg_wen && full) begin
         ovf_d = 1'b1;
      end
      if (push) begin
         fifo_adr_d[wr_ptr_q] = upg_adr;
         fifo_dat_d[wr_ptr_q] = upg_dat;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end

      // Keep the memory quiet in a reset cycle so queued data never lands after reset.
      if (rst) begin
         mem_en = 1'b0;
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         cpu_rdata_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         cpu_rdata_q <= cpu_rdata_d;
         ovf_q       <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_adr_q <= fifo_adr_d;
      fifo_dat_q <= fifo_dat_d;
   end

   assign ovf_err = ovf_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model built from a write queue and a memory image.
module tb_riscv_dmem_arbiter;

   localparam int unsigned AW    = 14;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned SMAX  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          upg_wen;
   logic [AW-1:0] upg_adr;
   logic [31:0]   upg_dat;
   logic          upg_full, mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;
   logic          prog_busy, ovf_err;

   always #5 clk = ~clk;

   riscv_dmem_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat), .upg_full(upg_full),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .prog_busy(prog_busy), .ovf_err(ovf_err)
   );

   // Synchronous single-port RAM with registered read data.
   logic [31:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   logic [31:0] ref_mem [0:(1<<AW)-1];
   wr_t         q[$];
   int unsigned starve;
   bit          rd_pending, ovf, hold, stall_obs;
   logic [31:0] rd_val, rdata_reg;
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_cycle();
      bit empty, full, gu, gc;
      stall_obs = cpu_stall;
      if (rst) begin
         chk("rst_mem_en", 32'(mem_en), 32'd0);
         q.delete();
         starve = 0; rd_pending = 0; rdata_reg = '0; ovf = 0; hold = 0;
         return;
      end
      empty = (q.size() == 0);
      full  = (q.size() == DEPTH);
      chk("upg_full", 32'(upg_full), 32'(full));
      chk("prog_busy", 32'(prog_busy), 32'(!empty));
      chk("ovf_err", 32'(ovf_err), 32'(ovf));
      if (rd_pending) begin
         chk("rd_mem_en", 32'(mem_en), 32'd0);
         chk("rd_stall", 32'(cpu_stall), 32'd0);
         chk("rd_rdata", cpu_rdata, rd_val);
         rdata_reg  = rd_val;
         rd_pending = 0;
         hold       = 0;
         if (empty) starve = 0;
      end else begin
         gu = !empty && (!cpu_req || starve == SMAX);
         gc = cpu_req && !gu;
         chk("hold_rdata", cpu_rdata, rdata_reg);
         if (gu) begin
            chk("upg_en", 32'(mem_en), 32'd1);
            chk("upg_we", 32'(mem_we), 32'd1);
            chk("upg_addr", 32'(mem_addr), 32'(q[0].a));
            chk("upg_data", mem_wdata, q[0].d);
            chk("upg_stall", 32'(cpu_stall), 32'(cpu_req));
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
            starve = 0;
            hold   = cpu_req;
         end else if (gc) begin
            chk("cpu_en", 32'(mem_en), 32'd1);
            chk("cpu_we", 32'(mem_we), 32'(cpu_we));
            chk("cpu_addr", 32'(mem_addr), 32'(cpu_addr));
            if (cpu_we) begin
               chk("st_data", mem_wdata, cpu_wdata);
               chk("st_stall", 32'(cpu_stall), 32'd0);
               ref_mem[cpu_addr] = cpu_wdata;
               hold = 0;
            end else begin
               chk("ld_stall", 32'(cpu_stall), 32'd1);
               rd_val     = ref_mem[cpu_addr];
               rd_pending = 1;
               hold       = 1;
            end
            if (empty) starve = 0;
            else if (starve < SMAX) starve++;
         end else begin
            chk("idle_en", 32'(mem_en), 32'd0);
            chk("idle_stall", 32'(cpu_stall), 32'd0);
            starve = 0;
            hold   = 0;
         end
      end
      if (upg_wen) begin
         if (full) ovf = 1;
         else      q.push_back('{upg_adr, upg_dat});
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic wen,
                        input logic [AW-1:0] ua, input logic [31:0] ud);
      if (!hold) begin
         cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      end
      upg_wen = wen; upg_adr = ua; upg_dat = ud;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; upg_wen = 1'b0;
      hold = 0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int first_stall;
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = '0; ref_mem[i] = '0;
      end
      ram[14'h10] = 32'hDEADBEEF; ref_mem[14'h10] = 32'hDEADBEEF;
      rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      upg_wen = 0; upg_adr = '0; upg_dat = '0;
      hold = 0; rd_pending = 0; starve = 0; ovf = 0; rdata_reg = '0; rd_val = '0;
      @(posedge clk); #1;
      do_reset();
      drive(0, 0, '0, '0, 0, '0, '0);

      // CPU load of 0x10
      drive(1, 0, 14'h10, '0, 0, '0, '0);
      drive(1, 0, 14'h10, '0, 0, '0, '0);
      chk("load_value", cpu_rdata, 32'hDEADBEEF);
      drive(0, 0, '0, '0, 0, '0, '0);

      // Reset while a read is in flight, with a queued write
      drive(1, 0, 14'h10, '0, 1, 14'h5, 32'h7);
      do_reset();
      drive(0, 0, '0, '0, 0, '0, '0);
      chk("post_rst_ram5", ram[14'h5], 32'h0);

      // Programmer only
      drive(0, 0, '0, '0, 1, 14'h1, 32'hA);
      drive(0, 0, '0, '0, 1, 14'h2, 32'hB);
      drive(0, 0, '0, '0, 1, 14'h3, 32'hC);
      drive(0, 0, '0, '0, 0, '0, '0);
      drive(0, 0, '0, '0, 0, '0, '0);
      chk("prog_ram3", ram[14'h3], 32'hC);

      // Starvation: one queued write against continuous stores
      drive(0, 0, '0, '0, 1, 14'h20, 32'h1234);
      first_stall = -1;
      for (int i = 0; i < 11; i++) begin
         drive(1, 1, 14'h40 + 14'(i), 32'h100 + i, 0, '0, '0);
         if (stall_obs && first_stall < 0) first_stall = i;
      end
      chk("starve_len", 32'(first_stall), 32'd8);
      drive(0, 0, '0, '0, 0, '0, '0);

      // Overflow under continuous loads
      do_reset();
      for (int i = 0; i < 90; i++)
         drive(1, 0, 14'($urandom_range(0, 255)), '0, i < 5, 14'h100 + 14'(i), 32'h5000 + i);
      for (int i = 0; i < 6; i++) drive(0, 0, '0, '0, 0, '0, '0);
      for (int i = 0; i < 4; i++) chk("ovf_kept", ram[14'h100 + 14'(i)], 32'h5000 + i);
      chk("ovf_dropped", ram[14'h104], 32'h0);
      chk("ovf_sticky", 32'(ovf_err), 32'd1);

      // Push and pop together while full
      do_reset();
      for (int i = 0; i < 4; i++)
         drive(1, 0, 14'h10, '0, 1, 14'h200 + 14'(i), 32'h6000 + i);
      drive(0, 0, '0, '0, 1, 14'h204, 32'h6004);
      chk("pp_ovf", 32'(ovf_err), 32'd1);
      chk("pp_notfull", 32'(upg_full), 32'd0);
      for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, 0, '0, '0);
      chk("pp_dropped", ram[14'h204], 32'h0);

      // Random traffic
      do_reset();
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               14'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2) == 0,
               14'($urandom_range(0, 63)), $urandom);
      for (int i = 0; i < 10; i++) drive(0, 0, '0, '0, 0, '0, '0);
      for (int i = 0; i < 64; i++) chk("final_mem", ram[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
